// File: rtl/xnor_popcnt_seq.sv
// xnor_popcnt_seq: sequences a programmed number of XNOR/popcount beats and
// presents match count, signed +/-1 dot product and threshold decision.
// Latency: in_ready one cycle after an accepted start; result one cycle after
// the last beat. Backpressure: in_ready/out_valid are pure state decodes, and
// the result holds while out_ready is low.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, cfg_len,     start a dot product (sampled only in IDLE), word count
//   cfg_thresh          and decision threshold, both latched on accepted start
//   busy                high whenever the sequencer is not IDLE
//   in_valid/in_ready   operand pair handshake carrying i_A / i_B
//   out_valid/out_ready result handshake carrying o_Sum / o_Dot / o_Bit
module xnor_popcnt_seq #(
  parameter int BW     = 8,
  parameter int NWORDS = 16,
  parameter int LENW   = $clog2(NWORDS + 1),
  parameter int ACCW   = $clog2(BW * NWORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LENW-1:0]   cfg_len,
  input  logic [ACCW-1:0]   cfg_thresh,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW-1:0]     i_A,
  input  logic [BW-1:0]     i_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   o_Sum,
  output logic [ACCW:0]     o_Dot,
  output logic              o_Bit
);

  localparam int PCW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   count_q, count_d;
  logic [ACCW-1:0]   thresh_q, thresh_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [ACCW-1:0]   sum_q, sum_d;
  logic [ACCW:0]     dot_q, dot_d;
  logic              bit_q, bit_d;

  // Combinational helpers for the datapath.
  logic [LENW-1:0]   len_clamped;
  logic [ACCW-1:0]   acc_next;
  logic [ACCW:0]     len_bits;
  logic              beat;
  logic              last_beat;

  function automatic logic [PCW-1:0] popcount(input logic [BW-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BW; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  // Oversized lengths saturate at the array depth rather than wrapping.
  assign len_clamped = (cfg_len > LENW'(NWORDS)) ? LENW'(NWORDS) : cfg_len;

  assign beat      = (state_q == S_ACC) && in_valid;
  assign last_beat = beat && (count_q == (len_q - LENW'(1)));
  assign acc_next  = acc_q + ACCW'(popcount(i_A ~^ i_B));

  // Bit count of the whole vector, used as the offset of the +/-1 dot product.
  assign len_bits  = (ACCW + 1)'(len_q) * (ACCW + 1)'(BW);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    thresh_d = thresh_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    dot_d    = dot_q;
    bit_d    = bit_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len_clamped;
          thresh_d = cfg_thresh;
          acc_d    = '0;
          count_d  = '0;
          sum_d    = '0;
          dot_d    = '0;
          if (len_clamped == '0) begin
            // Empty vector: result is known immediately, skip accumulation.
            bit_d   = (cfg_thresh == '0);
            state_d = S_OUT;
          end else begin
            bit_d   = 1'b0;
            state_d = S_ACC;
          end
        end
      end

      S_ACC: begin
        if (beat) begin
          acc_d   = acc_next;
          count_d = count_q + LENW'(1);
          if (last_beat) begin
            // Result registers take the final beat's contribution directly so
            // the answer is valid on the cycle after the last beat.
            sum_d   = acc_next;
            dot_d   = {1'b0, acc_next} + {1'b0, acc_next} - len_bits;
            bit_d   = (acc_next >= thresh_q);
            state_d = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      count_q  <= '0;
      thresh_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      dot_q    <= '0;
      bit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      dot_q    <= dot_d;
      bit_q    <= bit_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);

  assign o_Sum = sum_q;
  assign o_Dot = dot_q;
  assign o_Bit = bit_q;

endmodule

// File: tb/tb_xnor_popcnt_seq.sv
// Directed and random bench for xnor_popcnt_seq with a result scoreboard.
module tb_xnor_popcnt_seq;

  localparam int BW     = 8;
  localparam int NWORDS = 16;
  localparam int LENW   = $clog2(NWORDS + 1);
  localparam int ACCW   = $clog2(BW * NWORDS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LENW-1:0]   cfg_len;
  logic [ACCW-1:0]   cfg_thresh;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     i_A;
  logic [BW-1:0]     i_B;
  logic              out_valid;
  logic              out_ready;
  logic [ACCW-1:0]   o_Sum;
  logic [ACCW:0]     o_Dot;
  logic              o_Bit;

  always #5 clk = ~clk;

  xnor_popcnt_seq #(.BW(BW), .NWORDS(NWORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .i_A(i_A), .i_B(i_B), .out_valid(out_valid),
    .out_ready(out_ready), .o_Sum(o_Sum), .o_Dot(o_Dot), .o_Bit(o_Bit)
  );

  typedef struct packed {
    logic [ACCW-1:0] sum;
    logic [ACCW:0]   dot;
    logic            bt;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_sum;
  int   m_len;
  int   m_thresh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [BW-1:0] v);
    int n = 0;
    for (int i = 0; i < BW; i++) n += int'(v[i]);
    return n;
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    res_t r;
    r.sum = ACCW'(m_sum);
    r.dot = (ACCW + 1)'(2 * m_sum - m_len * BW);
    r.bt  = (m_sum >= m_thresh);
    sb.push_back(r);
  endtask

  task automatic do_start(input int len, input int th);
    check("idle_before_start", 32'(busy), 0);
    start      = 1'b1;
    cfg_len    = LENW'(len);
    cfg_thresh = ACCW'(th);
    tick();
    start      = 1'b0;
    m_len      = (len > NWORDS) ? NWORDS : len;
    m_thresh   = th;
    m_sum      = 0;
    check("busy_after_start", 32'(busy), 1);
    if (m_len == 0) begin
      push_expected();
      check("len0_out_valid", 32'(out_valid), 1);
    end else begin
      check("in_ready_after_start", 32'(in_ready), 1);
    end
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) tick();
    i_A      = a;
    i_B      = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    m_sum += popc(a ~^ b);
  endtask

  // Called right after the last beat: result must be visible one cycle later.
  task automatic end_beats();
    push_expected();
    check("out_valid_after_last", 32'(out_valid), 1);
    check("in_ready_in_out", 32'(in_ready), 0);
  endtask

  task automatic collect(input int delay);
    int   w;
    res_t r;
    w = 0;
    while (!out_valid && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("out_timeout", 0, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    r = sb.pop_front();
    repeat (delay) begin
      check("hold_sum", 32'(o_Sum), 32'(r.sum));
      check("hold_busy", 32'(busy), 1);
      tick();
    end
    check("o_Sum", 32'(o_Sum), 32'(r.sum));
    check("o_Dot", 32'(o_Dot), 32'(r.dot));
    check("o_Bit", 32'(o_Bit), 32'(r.bt));
    check("out_valid_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_accept", 32'(out_valid), 0);
    check("busy_after_accept", 32'(busy), 0);
  endtask

  initial begin
    logic [BW-1:0] ta [3];
    logic [BW-1:0] tb [3];
    int            len;

    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_thresh = '0;
    in_valid = 1'b0; i_A = '0; i_B = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(o_Sum), 0);
    check("rst_dot", 32'(o_Dot), 0);
    check("rst_bit", 32'(o_Bit), 0);
    reset = 1'b0;
    tick();

    // Reset mid-operation, with start held during reset.
    do_start(4, 0);
    send_beat(8'hFF, 8'hFF, 0);
    send_beat(8'h12, 8'h34, 0);
    reset = 1'b1; start = 1'b1; cfg_len = LENW'(2);
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_sum", 32'(o_Sum), 0);
    check("midrst_dot", 32'(o_Dot), 0);
    check("midrst_bit", 32'(o_Bit), 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("midrst_still_idle", 32'(busy), 0);
    do_start(1, 0);
    send_beat(8'hFF, 8'hFF, 0);
    end_beats();
    collect(0);

    // Full-length back-to-back: expect sum 12, dot 0, bit 1.
    ta = '{8'hFF, 8'h0F, 8'hAA};
    tb = '{8'hFF, 8'h00, 8'h55};
    do_start(3, 12);
    for (int i = 0; i < 3; i++) send_beat(ta[i], tb[i], 0);
    end_beats();
    collect(0);

    // Stalls on both handshakes.
    do_start(2, 9);
    send_beat(8'hF0, 8'hF0, 3);
    send_beat(8'h0F, 8'hF3, 3);
    end_beats();
    collect(5);

    // Length edge cases.
    do_start(0, 0);
    collect(0);
    do_start(0, 5);
    collect(1);
    do_start(31, 0);
    for (int i = 0; i < NWORDS; i++) send_beat(8'h00, 8'hFF, 0);
    end_beats();
    collect(0);

    // Ignored start during ACC/OUT and ignored in_valid during OUT/IDLE.
    do_start(3, 4);
    send_beat(8'h01, 8'h01, 0);
    start = 1'b1; cfg_len = LENW'(1); cfg_thresh = '0;
    tick();
    start = 1'b0;
    check("acc_start_ignored_ready", 32'(in_ready), 1);
    send_beat(8'h03, 8'h00, 0);
    send_beat(8'hC0, 8'hC0, 0);
    end_beats();
    in_valid = 1'b1; start = 1'b1; i_A = 8'hFF; i_B = 8'hFF;
    repeat (3) begin
      tick();
      check("out_in_ready_low", 32'(in_ready), 0);
      check("out_held_valid", 32'(out_valid), 1);
    end
    start = 1'b0; in_valid = 1'b0;
    collect(0);
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_in_ready_low", 32'(in_ready), 0);
      check("idle_busy_low", 32'(busy), 0);
    end
    in_valid = 1'b0;
    do_start(2, 16);
    send_beat(8'hFF, 8'hFF, 0);
    send_beat(8'hFF, 8'hFF, 0);
    end_beats();
    collect(0);

    // Random regression.
    for (int n = 0; n < 1000; n++) begin
      len = $urandom_range(0, 20);
      do_start(len, $urandom_range(0, 140));
      if (m_len > 0) begin
        for (int i = 0; i < m_len; i++)
          send_beat(BW'($urandom), BW'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end_beats();
      end
      collect($urandom_range(0, 2));
    end

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
